bus_cycle_master: RTL

Upstream bus master for the 8088-compatible bus. It converts single read/write requests from an internal requester into T1/T2/(TW)/T3 bus cycles on ALE, RD, WR, IO_M, ADDRESS and DATA. Those cycles are consumed by the memory/IO slave modules through the address decoder's CS. The block inserts wait states on READY, bounds them with a timeout, and returns read data with a completion pulse.

---
 rtl/bus_master_pkg.sv | 22 ++
 rtl/bus_cycle_master_if.sv | 38 +++
 rtl/bus_wait_timer.sv | 41 ++++
 rtl/bus_cycle_master.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared types and default sizing for the 8088-style bus cycle master.
// The state encoding is shared so the bench and any debug tooling can decode it.
package bus_master_pkg;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_WAIT   = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } bus_state_e;

  // A new request may be taken while idle or while the current cycle is in T3.
  function automatic logic state_accepts(input bus_state_e s);
    return (s == IDLE) || (s == T3);
  endfunction

endpackage

// File: rtl/bus_cycle_master_if.sv
// Requester handshake plus the unidirectional bus strobes/address of the cycle master.
// The bidirectional DATA bus is a separate inout port on the master.
interface bus_cycle_master_if #(
  parameter int ADDR_WIDTH = bus_master_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_master_pkg::DEF_DATA_WIDTH
) ();
  import bus_master_pkg::*;

  // Requester side
  logic                  REQ;
  logic                  REQ_WE;
  logic                  REQ_IOM;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  REQ_RDY;
  logic                  DONE;
  logic                  ERR;
  logic [DATA_WIDTH-1:0] RDATA;

  // Bus side
  logic                  ALE;
  logic                  RD;
  logic                  WR;
  logic                  IO_M;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic                  READY;

  modport master (
    input  REQ, REQ_WE, REQ_IOM, REQ_ADDR, REQ_WDATA, READY,
    output REQ_RDY, DONE, ERR, RDATA, ALE, RD, WR, IO_M, ADDRESS
  );

  modport slave (
    output REQ, REQ_WE, REQ_IOM, REQ_ADDR, REQ_WDATA, READY,
    input  REQ_RDY, DONE, ERR, RDATA, ALE, RD, WR, IO_M, ADDRESS
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared before the first TW, counts TW cycles, and flags the
// cycle whose increment would reach MAX_WAIT so the FSM can leave on that edge.
module bus_wait_timer
  import bus_master_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] SAT_VAL  = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == LAST_VAL);

endmodule

// File: rtl/bus_cycle_master.sv
// Converts single read/write requests into T1/T2/(TW)/T3 cycles on the 8088-style bus,
// with READY-driven wait states bounded by a timeout.
module bus_cycle_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_cycle_master_if.master    bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  bus_state_e            state_q;
  logic                  ale_q;
  logic                  rd_n_q;
  logic                  wr_n_q;
  logic                  iom_q;
  logic                  we_q;
  logic                  drive_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic req_rdy;
  logic timer_clr;
  logic timer_en;
  logic timer_tc;
  logic finish_now;
  logic timeout_now;

  assign req_rdy   = state_accepts(state_q);
  assign timer_clr = (state_q == T2);
  assign timer_en  = (state_q == TW);

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // The data phase ends on READY, or on the last permitted TW with READY still low.
  always_comb begin
    finish_now  = 1'b0;
    timeout_now = 1'b0;
    if (state_q == T2) begin
      finish_now = bus.READY;
    end else if (state_q == TW) begin
      finish_now  = bus.READY || timer_tc;
      timeout_now = !bus.READY && timer_tc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ale_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      iom_q   <= 1'b0;
      we_q    <= 1'b0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, T3: begin
          drive_q <= 1'b0;
          if (bus.REQ) begin
            state_q <= T1;
            ale_q   <= 1'b1;
            addr_q  <= bus.REQ_ADDR;
            iom_q   <= bus.REQ_IOM;
            we_q    <= bus.REQ_WE;
            wdata_q <= bus.REQ_WDATA;
          end else begin
            state_q <= IDLE;
          end
        end
        T1: begin
          state_q <= T2;
          ale_q   <= 1'b0;
          rd_n_q  <= we_q;
          wr_n_q  <= !we_q;
          drive_q <= we_q;
        end
        T2, TW: begin
          if (finish_now) begin
            // Strobes rise into T3; write data keeps driving for hold time.
            state_q <= T3;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            done_q  <= 1'b1;
            err_q   <= timeout_now;
            if (timeout_now) begin
              rdata_q <= '1;
            end else if (!we_q) begin
              rdata_q <= DATA;
            end
          end else begin
            state_q <= TW;
          end
        end
        default: begin
          state_q <= IDLE;
          ale_q   <= 1'b0;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign DATA        = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign bus.REQ_RDY = req_rdy;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.RDATA   = rdata_q;
  assign bus.ALE     = ale_q;
  assign bus.RD      = rd_n_q;
  assign bus.WR      = wr_n_q;
  assign bus.IO_M    = iom_q;
  assign bus.ADDRESS = addr_q;

endmodule
